// File: rtl/mips_ctrl_pkg.sv
// Shared constants for the multicycle MIPS main control FSM: state encoding,
// opcodes, ALU operation codes handed to the ALU control block, and the control vector.
package mips_ctrl_pkg;

    localparam logic [3:0] S_IDLE      = 4'd0;
    localparam logic [3:0] S_FETCH     = 4'd1;
    localparam logic [3:0] S_DECODE    = 4'd2;
    localparam logic [3:0] S_MEM_ADDR  = 4'd3;
    localparam logic [3:0] S_MEM_READ  = 4'd4;
    localparam logic [3:0] S_MEM_WB    = 4'd5;
    localparam logic [3:0] S_MEM_WRITE = 4'd6;
    localparam logic [3:0] S_R_EXEC    = 4'd7;
    localparam logic [3:0] S_R_WB      = 4'd8;
    localparam logic [3:0] S_BRANCH    = 4'd9;
    localparam logic [3:0] S_JUMP      = 4'd10;
    localparam logic [3:0] S_I_EXEC    = 4'd11;
    localparam logic [3:0] S_I_WB      = 4'd12;
    localparam logic [3:0] S_ILLEGAL   = 4'd13;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_SLTI  = 6'h0A;

    // 4'b0100 is reserved by the ALU control block and is never issued.
    localparam logic [3:0] ALU_OP_ADD   = 4'b0000;
    localparam logic [3:0] ALU_OP_SUB   = 4'b0001;
    localparam logic [3:0] ALU_OP_FUNCT = 4'b0010;
    localparam logic [3:0] ALU_OP_AND   = 4'b0011;
    localparam logic [3:0] ALU_OP_OR    = 4'b0101;
    localparam logic [3:0] ALU_OP_SLT   = 4'b0110;

    localparam logic [1:0] PC_SRC_ALU    = 2'b00;
    localparam logic [1:0] PC_SRC_ALUOUT = 2'b01;
    localparam logic [1:0] PC_SRC_JUMP   = 2'b10;

    localparam logic [1:0] SRC_B_REG    = 2'b00;
    localparam logic [1:0] SRC_B_FOUR   = 2'b01;
    localparam logic [1:0] SRC_B_IMM    = 2'b10;
    localparam logic [1:0] SRC_B_IMM_SH = 2'b11;

    typedef struct packed {
        logic       mem_read;
        logic       mem_write;
        logic       i_or_d;
        logic       ir_write;
        logic       pc_write;
        logic       pc_write_cond;
        logic       pc_write_cond_ne;
        logic [1:0] pc_source;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [3:0] alu_op;
        logic       reg_write;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       illegal_op;
    } ctrl_t;

    function automatic logic [3:0] imm_alu_op(input logic [5:0] op);
        case (op)
            OP_ANDI: imm_alu_op = ALU_OP_AND;
            OP_ORI:  imm_alu_op = ALU_OP_OR;
            OP_SLTI: imm_alu_op = ALU_OP_SLT;
            default: imm_alu_op = ALU_OP_ADD;
        endcase
    endfunction

    function automatic logic [3:0] decode_dispatch(input logic [5:0] op);
        case (op)
            OP_RTYPE:                         decode_dispatch = S_R_EXEC;
            OP_LW, OP_SW:                     decode_dispatch = S_MEM_ADDR;
            OP_BEQ, OP_BNE:                   decode_dispatch = S_BRANCH;
            OP_J:                             decode_dispatch = S_JUMP;
            OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI: decode_dispatch = S_I_EXEC;
            default:                          decode_dispatch = S_ILLEGAL;
        endcase
    endfunction

endpackage

// File: rtl/mips_multicycle_control_if.sv
// Control bundle between the main control FSM (master) and the datapath (slave).
interface mips_multicycle_control_if;
    logic [5:0] opcode;
    logic       mem_ready;
    logic       mem_read;
    logic       mem_write;
    logic       i_or_d;
    logic       ir_write;
    logic       pc_write;
    logic       pc_write_cond;
    logic       pc_write_cond_ne;
    logic [1:0] pc_source;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [3:0] alu_op;
    logic       reg_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       illegal_op;

    modport master (
        input  opcode, mem_ready,
        output mem_read, mem_write, i_or_d, ir_write, pc_write, pc_write_cond,
               pc_write_cond_ne, pc_source, alu_src_a, alu_src_b, alu_op,
               reg_write, reg_dst, mem_to_reg, illegal_op
    );

    modport slave (
        output opcode, mem_ready,
        input  mem_read, mem_write, i_or_d, ir_write, pc_write, pc_write_cond,
               pc_write_cond_ne, pc_source, alu_src_a, alu_src_b, alu_op,
               reg_write, reg_dst, mem_to_reg, illegal_op
    );
endinterface

// File: rtl/mips_ctrl_outdec.sv
// Combinational control-vector decoder: Moore decode of state, with the FETCH
// strobes gated by mem_ready and the I-type ALU operation chosen by opcode.
module mips_ctrl_outdec
    import mips_ctrl_pkg::*;
(
    input  logic [3:0] state,
    input  logic [5:0] opcode,
    input  logic       mem_ready,
    output ctrl_t      ctrl
);

    always_comb begin
        ctrl = '0;
        case (state)
            S_FETCH: begin
                ctrl.mem_read  = 1'b1;
                ctrl.i_or_d    = 1'b0;
                ctrl.alu_src_a = 1'b0;
                ctrl.alu_src_b = SRC_B_FOUR;
                ctrl.alu_op    = ALU_OP_ADD;
                ctrl.pc_source = PC_SRC_ALU;
                // IR and PC load only on the cycle the instruction word arrives.
                ctrl.ir_write  = mem_ready;
                ctrl.pc_write  = mem_ready;
            end
            S_DECODE: begin
                ctrl.alu_src_a = 1'b0;
                ctrl.alu_src_b = SRC_B_IMM_SH;
                ctrl.alu_op    = ALU_OP_ADD;
            end
            S_MEM_ADDR: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRC_B_IMM;
                ctrl.alu_op    = ALU_OP_ADD;
            end
            S_MEM_READ: begin
                ctrl.mem_read = 1'b1;
                ctrl.i_or_d   = 1'b1;
            end
            S_MEM_WB: begin
                ctrl.reg_write  = 1'b1;
                ctrl.mem_to_reg = 1'b1;
                ctrl.reg_dst    = 1'b0;
            end
            S_MEM_WRITE: begin
                ctrl.mem_write = 1'b1;
                ctrl.i_or_d    = 1'b1;
            end
            S_R_EXEC: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRC_B_REG;
                ctrl.alu_op    = ALU_OP_FUNCT;
            end
            S_R_WB: begin
                ctrl.reg_write = 1'b1;
                ctrl.reg_dst   = 1'b1;
            end
            S_BRANCH: begin
                ctrl.alu_src_a        = 1'b1;
                ctrl.alu_src_b        = SRC_B_REG;
                ctrl.alu_op           = ALU_OP_SUB;
                ctrl.pc_source        = PC_SRC_ALUOUT;
                ctrl.pc_write_cond    = (opcode == OP_BEQ);
                ctrl.pc_write_cond_ne = (opcode == OP_BNE);
            end
            S_JUMP: begin
                ctrl.pc_write  = 1'b1;
                ctrl.pc_source = PC_SRC_JUMP;
            end
            S_I_EXEC: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRC_B_IMM;
                ctrl.alu_op    = imm_alu_op(opcode);
            end
            S_I_WB: begin
                ctrl.reg_write  = 1'b1;
                ctrl.reg_dst    = 1'b0;
                ctrl.mem_to_reg = 1'b0;
            end
            S_ILLEGAL: begin
                ctrl.illegal_op = 1'b1;
            end
            default: ctrl = '0;
        endcase
    end

endmodule

// File: rtl/mips_multicycle_control.sv
// Multicycle MIPS main control: state register, next-state sequencing with
// memory-ready stalls, and a wrapping retired-instruction counter.
module mips_multicycle_control
    import mips_ctrl_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic                    clk,
    input  logic                    rst_n,
    mips_multicycle_control_if.master bus,
    output logic [CNT_W-1:0]        instr_count,
    output logic [3:0]              state_dbg
);

    logic [3:0]       state_reg;
    logic [3:0]       state_next;
    logic [CNT_W-1:0] count_reg;
    logic             retire;
    ctrl_t            ctrl;

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE:      state_next = S_FETCH;
            S_FETCH:     state_next = bus.mem_ready ? S_DECODE : S_FETCH;
            S_DECODE:    state_next = decode_dispatch(bus.opcode);
            S_MEM_ADDR:  state_next = (bus.opcode == OP_SW) ? S_MEM_WRITE : S_MEM_READ;
            S_MEM_READ:  state_next = bus.mem_ready ? S_MEM_WB : S_MEM_READ;
            S_MEM_WB:    state_next = S_FETCH;
            S_MEM_WRITE: state_next = bus.mem_ready ? S_FETCH : S_MEM_WRITE;
            S_R_EXEC:    state_next = S_R_WB;
            S_R_WB:      state_next = S_FETCH;
            S_BRANCH:    state_next = S_FETCH;
            S_JUMP:      state_next = S_FETCH;
            S_I_EXEC:    state_next = S_I_WB;
            S_I_WB:      state_next = S_FETCH;
            S_ILLEGAL:   state_next = S_FETCH;
            default:     state_next = S_IDLE;
        endcase
    end

    // An instruction retires on its final transition back to FETCH; ILLEGAL does not count.
    always_comb begin
        retire = 1'b0;
        case (state_reg)
            S_MEM_WB, S_R_WB, S_BRANCH, S_JUMP, S_I_WB: retire = 1'b1;
            S_MEM_WRITE:                                retire = bus.mem_ready;
            default:                                    retire = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= S_IDLE;
            count_reg <= '0;
        end else begin
            state_reg <= state_next;
            if (retire) begin
                count_reg <= count_reg + CNT_W'(1);
            end
        end
    end

    mips_ctrl_outdec u_outdec (
        .state     (state_reg),
        .opcode    (bus.opcode),
        .mem_ready (bus.mem_ready),
        .ctrl      (ctrl)
    );

    assign bus.mem_read         = ctrl.mem_read;
    assign bus.mem_write        = ctrl.mem_write;
    assign bus.i_or_d           = ctrl.i_or_d;
    assign bus.ir_write         = ctrl.ir_write;
    assign bus.pc_write         = ctrl.pc_write;
    assign bus.pc_write_cond    = ctrl.pc_write_cond;
    assign bus.pc_write_cond_ne = ctrl.pc_write_cond_ne;
    assign bus.pc_source        = ctrl.pc_source;
    assign bus.alu_src_a        = ctrl.alu_src_a;
    assign bus.alu_src_b        = ctrl.alu_src_b;
    assign bus.alu_op           = ctrl.alu_op;
    assign bus.reg_write        = ctrl.reg_write;
    assign bus.reg_dst          = ctrl.reg_dst;
    assign bus.mem_to_reg       = ctrl.mem_to_reg;
    assign bus.illegal_op       = ctrl.illegal_op;

    assign instr_count = count_reg;
    assign state_dbg   = state_reg;

endmodule

// File: tb/tb_mips_multicycle_control.sv
// Directed bench for the multicycle MIPS control FSM; a 4-bit-counter copy
// runs in lockstep to exercise counter wrap.
module tb_mips_multicycle_control;
  import mips_ctrl_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  mips_multicycle_control_if b ();
  mips_multicycle_control_if b4 ();
  assign b4.opcode    = b.opcode;
  assign b4.mem_ready = b.mem_ready;

  logic [31:0] instr_count;
  logic [3:0]  state_dbg;
  logic [3:0]  count4;
  logic [3:0]  state4;

  mips_multicycle_control #(.CNT_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .bus(b), .instr_count(instr_count), .state_dbg(state_dbg));
  mips_multicycle_control #(.CNT_W(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .bus(b4), .instr_count(count4), .state_dbg(state4));

  // {mr mw iod irw pcw pwc pwcne} pcs sa sb aop {rw rd m2r ill}
  wire [19:0] ctl = {b.mem_read, b.mem_write, b.i_or_d, b.ir_write, b.pc_write,
                     b.pc_write_cond, b.pc_write_cond_ne, b.pc_source, b.alu_src_a,
                     b.alu_src_b, b.alu_op, b.reg_write, b.reg_dst, b.mem_to_reg,
                     b.illegal_op};

  localparam logic [19:0] V_IDLE       = 20'd0;
  localparam logic [19:0] V_FETCH_RDY  = {7'b1001100, 2'b00, 1'b0, 2'b01, 4'b0000, 4'b0000};
  localparam logic [19:0] V_FETCH_WAIT = {7'b1000000, 2'b00, 1'b0, 2'b01, 4'b0000, 4'b0000};
  localparam logic [19:0] V_DECODE     = {7'b0000000, 2'b00, 1'b0, 2'b11, 4'b0000, 4'b0000};
  localparam logic [19:0] V_MEM_ADDR   = {7'b0000000, 2'b00, 1'b1, 2'b10, 4'b0000, 4'b0000};
  localparam logic [19:0] V_MEM_READ   = {7'b1010000, 2'b00, 1'b0, 2'b00, 4'b0000, 4'b0000};
  localparam logic [19:0] V_MEM_WB     = {7'b0000000, 2'b00, 1'b0, 2'b00, 4'b0000, 4'b1010};
  localparam logic [19:0] V_MEM_WRITE  = {7'b0110000, 2'b00, 1'b0, 2'b00, 4'b0000, 4'b0000};
  localparam logic [19:0] V_R_EXEC     = {7'b0000000, 2'b00, 1'b1, 2'b00, 4'b0010, 4'b0000};
  localparam logic [19:0] V_R_WB       = {7'b0000000, 2'b00, 1'b0, 2'b00, 4'b0000, 4'b1100};
  localparam logic [19:0] V_BEQ        = {7'b0000010, 2'b01, 1'b1, 2'b00, 4'b0001, 4'b0000};
  localparam logic [19:0] V_BNE        = {7'b0000001, 2'b01, 1'b1, 2'b00, 4'b0001, 4'b0000};
  localparam logic [19:0] V_JUMP       = {7'b0000100, 2'b10, 1'b0, 2'b00, 4'b0000, 4'b0000};
  localparam logic [19:0] V_ADDI       = {7'b0000000, 2'b00, 1'b1, 2'b10, 4'b0000, 4'b0000};
  localparam logic [19:0] V_ANDI       = {7'b0000000, 2'b00, 1'b1, 2'b10, 4'b0011, 4'b0000};
  localparam logic [19:0] V_ORI        = {7'b0000000, 2'b00, 1'b1, 2'b10, 4'b0101, 4'b0000};
  localparam logic [19:0] V_SLTI       = {7'b0000000, 2'b00, 1'b1, 2'b10, 4'b0110, 4'b0000};
  localparam logic [19:0] V_I_WB       = {7'b0000000, 2'b00, 1'b0, 2'b00, 4'b0000, 4'b1000};
  localparam logic [19:0] V_ILLEGAL    = {7'b0000000, 2'b00, 1'b0, 2'b00, 4'b0000, 4'b0001};

  typedef struct packed {
    logic [5:0]  op;
    logic        rdy;
    logic [3:0]  st;
    logic [19:0] v;
  } step_t;

  int tests = 0;
  int fails = 0;
  logic [31:0] exp_count;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic test_reset();
    step_t seq[$];
    rst_n = 1'b0; b.opcode = 6'h00; b.mem_ready = 1'b1;
    @(posedge clk); #1;
    tests++;
    if ({state_dbg, ctl, instr_count, count4} !== {S_IDLE, V_IDLE, 32'd0, 4'd0}) begin
      fails++;
      $display("FAIL reset_hold got st=%h ctl=%05h cnt=%0d want st=%h ctl=%05h cnt=0",
               state_dbg, ctl, instr_count, S_IDLE, V_IDLE);
    end
    rst_n = 1'b1; exp_count = 0;
    seq.push_back(step_t'{6'h00, 1'b1, S_IDLE,   V_IDLE});
    seq.push_back(step_t'{6'h00, 1'b1, S_FETCH,  V_FETCH_RDY});
    seq.push_back(step_t'{6'h00, 1'b1, S_DECODE, V_DECODE});
    seq.push_back(step_t'{6'h00, 1'b1, S_R_EXEC, V_R_EXEC});
    seq.push_back(step_t'{6'h00, 1'b1, S_R_WB,   V_R_WB});
    foreach (seq[i]) begin
      b.opcode = seq[i].op; b.mem_ready = seq[i].rdy; #1;
      tests++;
      if ({state_dbg, ctl} !== {seq[i].st, seq[i].v}) begin
        fails++;
        $display("FAIL rtype[%0d] got st=%h ctl=%05h want st=%h ctl=%05h",
                 i, state_dbg, ctl, seq[i].st, seq[i].v);
      end
      @(posedge clk); #1;
    end
    exp_count = exp_count + 1;
    tests++;
    if ({state_dbg, instr_count, count4} !== {S_FETCH, exp_count, exp_count[3:0]}) begin
      fails++;
      $display("FAIL rtype_count got st=%h cnt=%0d cnt4=%0d want st=%h cnt=%0d",
               state_dbg, instr_count, count4, S_FETCH, exp_count);
    end
    $display("[TB] reset + R-type done, instr_count=%0d", instr_count);
  endtask

  task automatic test_lw();
    step_t seq[$];
    seq.push_back(step_t'{6'h23, 1'b1, S_FETCH,    V_FETCH_RDY});
    seq.push_back(step_t'{6'h23, 1'b1, S_DECODE,   V_DECODE});
    seq.push_back(step_t'{6'h23, 1'b1, S_MEM_ADDR, V_MEM_ADDR});
    seq.push_back(step_t'{6'h23, 1'b0, S_MEM_READ, V_MEM_READ});
    seq.push_back(step_t'{6'h23, 1'b0, S_MEM_READ, V_MEM_READ});
    seq.push_back(step_t'{6'h23, 1'b1, S_MEM_READ, V_MEM_READ});
    seq.push_back(step_t'{6'h23, 1'b1, S_MEM_WB,   V_MEM_WB});
    foreach (seq[i]) begin
      b.opcode = seq[i].op; b.mem_ready = seq[i].rdy; #1;
      tests++;
      if ({state_dbg, ctl} !== {seq[i].st, seq[i].v}) begin
        fails++;
        $display("FAIL lw[%0d] got st=%h ctl=%05h want st=%h ctl=%05h",
                 i, state_dbg, ctl, seq[i].st, seq[i].v);
      end
      @(posedge clk); #1;
    end
    exp_count = exp_count + 1;
    tests++;
    if ({state_dbg, instr_count, count4} !== {S_FETCH, exp_count, exp_count[3:0]}) begin
      fails++;
      $display("FAIL lw_count got st=%h cnt=%0d cnt4=%0d want st=%h cnt=%0d",
               state_dbg, instr_count, count4, S_FETCH, exp_count);
    end
    $display("[TB] lw with 2 wait states done, instr_count=%0d", instr_count);
  endtask

  task automatic test_branch();
    step_t seq[$];
    seq.push_back(step_t'{6'h04, 1'b1, S_FETCH,  V_FETCH_RDY});
    seq.push_back(step_t'{6'h04, 1'b1, S_DECODE, V_DECODE});
    seq.push_back(step_t'{6'h04, 1'b1, S_BRANCH, V_BEQ});
    seq.push_back(step_t'{6'h05, 1'b1, S_FETCH,  V_FETCH_RDY});
    seq.push_back(step_t'{6'h05, 1'b1, S_DECODE, V_DECODE});
    seq.push_back(step_t'{6'h05, 1'b1, S_BRANCH, V_BNE});
    foreach (seq[i]) begin
      b.opcode = seq[i].op; b.mem_ready = seq[i].rdy; #1;
      tests++;
      if ({state_dbg, ctl} !== {seq[i].st, seq[i].v}) begin
        fails++;
        $display("FAIL branch[%0d] got st=%h ctl=%05h want st=%h ctl=%05h",
                 i, state_dbg, ctl, seq[i].st, seq[i].v);
      end
      @(posedge clk); #1;
    end
    exp_count = exp_count + 2;
    tests++;
    if ({state_dbg, instr_count, count4} !== {S_FETCH, exp_count, exp_count[3:0]}) begin
      fails++;
      $display("FAIL branch_count got st=%h cnt=%0d cnt4=%0d want st=%h cnt=%0d",
               state_dbg, instr_count, count4, S_FETCH, exp_count);
    end
    $display("[TB] beq + bne done, instr_count=%0d", instr_count);
  endtask

  task automatic test_itype();
    step_t seq[$];
    logic [5:0]  ops  [4] = '{6'h0C, 6'h0D, 6'h0A, 6'h08};
    logic [19:0] vecs [4] = '{V_ANDI, V_ORI, V_SLTI, V_ADDI};
    for (int k = 0; k < 4; k++) begin
      seq.push_back(step_t'{ops[k], 1'b1, S_FETCH,  V_FETCH_RDY});
      seq.push_back(step_t'{ops[k], 1'b1, S_DECODE, V_DECODE});
      seq.push_back(step_t'{ops[k], 1'b1, S_I_EXEC, vecs[k]});
      seq.push_back(step_t'{ops[k], 1'b1, S_I_WB,   V_I_WB});
    end
    foreach (seq[i]) begin
      b.opcode = seq[i].op; b.mem_ready = seq[i].rdy; #1;
      tests++;
      if ({state_dbg, ctl} !== {seq[i].st, seq[i].v}) begin
        fails++;
        $display("FAIL itype[%0d] got st=%h ctl=%05h want st=%h ctl=%05h",
                 i, state_dbg, ctl, seq[i].st, seq[i].v);
      end
      @(posedge clk); #1;
    end
    exp_count = exp_count + 4;
    tests++;
    if ({state_dbg, instr_count, count4} !== {S_FETCH, exp_count, exp_count[3:0]}) begin
      fails++;
      $display("FAIL itype_count got st=%h cnt=%0d cnt4=%0d want st=%h cnt=%0d",
               state_dbg, instr_count, count4, S_FETCH, exp_count);
    end
    $display("[TB] andi/ori/slti/addi done, instr_count=%0d", instr_count);
  endtask

  task automatic test_jump_sw();
    step_t seq[$];
    seq.push_back(step_t'{6'h02, 1'b1, S_FETCH,     V_FETCH_RDY});
    seq.push_back(step_t'{6'h02, 1'b1, S_DECODE,    V_DECODE});
    seq.push_back(step_t'{6'h02, 1'b1, S_JUMP,      V_JUMP});
    seq.push_back(step_t'{6'h2B, 1'b0, S_FETCH,     V_FETCH_WAIT});
    seq.push_back(step_t'{6'h2B, 1'b1, S_FETCH,     V_FETCH_RDY});
    seq.push_back(step_t'{6'h2B, 1'b1, S_DECODE,    V_DECODE});
    seq.push_back(step_t'{6'h2B, 1'b1, S_MEM_ADDR,  V_MEM_ADDR});
    seq.push_back(step_t'{6'h2B, 1'b0, S_MEM_WRITE, V_MEM_WRITE});
    seq.push_back(step_t'{6'h2B, 1'b1, S_MEM_WRITE, V_MEM_WRITE});
    foreach (seq[i]) begin
      b.opcode = seq[i].op; b.mem_ready = seq[i].rdy; #1;
      tests++;
      if ({state_dbg, ctl} !== {seq[i].st, seq[i].v}) begin
        fails++;
        $display("FAIL jump_sw[%0d] got st=%h ctl=%05h want st=%h ctl=%05h",
                 i, state_dbg, ctl, seq[i].st, seq[i].v);
      end
      @(posedge clk); #1;
    end
    exp_count = exp_count + 2;
    tests++;
    if ({state_dbg, instr_count, count4} !== {S_FETCH, exp_count, exp_count[3:0]}) begin
      fails++;
      $display("FAIL jump_sw_count got st=%h cnt=%0d cnt4=%0d want st=%h cnt=%0d",
               state_dbg, instr_count, count4, S_FETCH, exp_count);
    end
    $display("[TB] j + sw with waits done, instr_count=%0d", instr_count);
  endtask

  task automatic test_illegal();
    step_t seq[$];
    seq.push_back(step_t'{6'h3F, 1'b1, S_FETCH,   V_FETCH_RDY});
    seq.push_back(step_t'{6'h3F, 1'b1, S_DECODE,  V_DECODE});
    seq.push_back(step_t'{6'h3F, 1'b1, S_ILLEGAL, V_ILLEGAL});
    seq.push_back(step_t'{6'h3F, 1'b0, S_FETCH,   V_FETCH_WAIT});
    foreach (seq[i]) begin
      b.opcode = seq[i].op; b.mem_ready = seq[i].rdy; #1;
      tests++;
      if ({state_dbg, ctl} !== {seq[i].st, seq[i].v}) begin
        fails++;
        $display("FAIL illegal[%0d] got st=%h ctl=%05h want st=%h ctl=%05h",
                 i, state_dbg, ctl, seq[i].st, seq[i].v);
      end
      @(posedge clk); #1;
    end
    tests++;
    if ({state_dbg, instr_count, count4} !== {S_FETCH, exp_count, exp_count[3:0]}) begin
      fails++;
      $display("FAIL illegal_count got st=%h cnt=%0d cnt4=%0d want st=%h cnt=%0d",
               state_dbg, instr_count, count4, S_FETCH, exp_count);
    end
    $display("[TB] illegal opcode 0x3F done, instr_count=%0d", instr_count);
  endtask

  task automatic test_wrap();
    step_t seq[$];
    // Bring the 4-bit copy to all-ones, then retire one more.
    while (exp_count[3:0] != 4'hF) begin
      seq.push_back(step_t'{6'h02, 1'b1, S_FETCH,  V_FETCH_RDY});
      seq.push_back(step_t'{6'h02, 1'b1, S_DECODE, V_DECODE});
      seq.push_back(step_t'{6'h02, 1'b1, S_JUMP,   V_JUMP});
      exp_count = exp_count + 1;
    end
    foreach (seq[i]) begin
      b.opcode = seq[i].op; b.mem_ready = seq[i].rdy; #1;
      tests++;
      if ({state_dbg, ctl} !== {seq[i].st, seq[i].v}) begin
        fails++;
        $display("FAIL wrap[%0d] got st=%h ctl=%05h want st=%h ctl=%05h",
                 i, state_dbg, ctl, seq[i].st, seq[i].v);
      end
      @(posedge clk); #1;
    end
    tests++;
    if ({instr_count, count4} !== {exp_count, 4'hF}) begin
      fails++;
      $display("FAIL wrap_allones got cnt=%0d cnt4=%h want cnt=%0d cnt4=f",
               instr_count, count4, exp_count);
    end
    b.opcode = 6'h02; b.mem_ready = 1'b1;
    repeat (3) begin @(posedge clk); #1; end
    exp_count = exp_count + 1;
    tests++;
    if ({state_dbg, state4, instr_count, count4} !== {S_FETCH, S_FETCH, exp_count, 4'h0}) begin
      fails++;
      $display("FAIL wrap_zero got st=%h st4=%h cnt=%0d cnt4=%h want st=%h cnt=%0d cnt4=0",
               state_dbg, state4, instr_count, count4, S_FETCH, exp_count);
    end
    $display("[TB] counter wrap done, instr_count=%0d count4=%0d", instr_count, count4);
  endtask

  task automatic test_reset_mid();
    step_t seq[$];
    seq.push_back(step_t'{6'h2B, 1'b1, S_FETCH,    V_FETCH_RDY});
    seq.push_back(step_t'{6'h2B, 1'b1, S_DECODE,   V_DECODE});
    seq.push_back(step_t'{6'h2B, 1'b1, S_MEM_ADDR, V_MEM_ADDR});
    seq.push_back(step_t'{6'h2B, 1'b0, S_MEM_WRITE, V_MEM_WRITE});
    foreach (seq[i]) begin
      b.opcode = seq[i].op; b.mem_ready = seq[i].rdy; #1;
      tests++;
      if ({state_dbg, ctl} !== {seq[i].st, seq[i].v}) begin
        fails++;
        $display("FAIL midrst[%0d] got st=%h ctl=%05h want st=%h ctl=%05h",
                 i, state_dbg, ctl, seq[i].st, seq[i].v);
      end
      if (i < seq.size() - 1) begin @(posedge clk); #1; end
    end
    rst_n = 1'b0; #1;
    exp_count = 0;
    tests++;
    if ({b.mem_write, state_dbg, ctl, instr_count, count4} !== {1'b0, S_IDLE, V_IDLE, 32'd0, 4'd0}) begin
      fails++;
      $display("FAIL midrst_async got mw=%b st=%h ctl=%05h cnt=%0d want mw=0 st=%h ctl=0 cnt=0",
               b.mem_write, state_dbg, ctl, instr_count, S_IDLE);
    end
    @(posedge clk); #1;
    rst_n = 1'b1; b.mem_ready = 1'b1;
    #1;
    tests++;
    if ({state_dbg, ctl} !== {S_IDLE, V_IDLE}) begin
      fails++;
      $display("FAIL midrst_idle got st=%h ctl=%05h want st=%h ctl=0", state_dbg, ctl, S_IDLE);
    end
    @(posedge clk); #1;
    tests++;
    if ({state_dbg, ctl, instr_count} !== {S_FETCH, V_FETCH_RDY, exp_count}) begin
      fails++;
      $display("FAIL midrst_fetch got st=%h ctl=%05h cnt=%0d want st=%h ctl=%05h cnt=0",
               state_dbg, ctl, instr_count, S_FETCH, V_FETCH_RDY);
    end
    $display("[TB] reset during sw wait done, instr_count=%0d", instr_count);
  endtask

  initial begin
    test_reset();
    test_lw();
    test_branch();
    test_itype();
    test_jump_sw();
    test_illegal();
    test_wrap();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
